// File: rtl/log_mult_seq_ctrl.sv
// Sequential Mitchell logarithmic multiplier: one shared leading-one detector
// normalises A then B, and the summed logs are converted back to a 32-bit product.

module hierarchical_lod_16bit (
  input  logic [15:0] data,
  output logic [3:0]  pos
);

  logic [3:0] nz;
  logic [7:0] nib_pos;

  function automatic logic [1:0] lod4(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  // Nibble-level detectors feed a second-level priority select.
  for (genvar n = 0; n < 4; n++) begin : g_nib
    assign nz[n]            = |data[4*n +: 4];
    assign nib_pos[2*n +: 2] = lod4(data[4*n +: 4]);
  end

  always_comb begin
    pos = {2'd0, nib_pos[1:0]};
    if (nz[3])      pos = {2'd3, nib_pos[7:6]};
    else if (nz[2]) pos = {2'd2, nib_pos[5:4]};
    else if (nz[1]) pos = {2'd1, nib_pos[3:2]};
  end

endmodule

module log_mult_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_p,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOD_A = 3'd1;
  localparam logic [2:0] LOD_B = 3'd2;
  localparam logic [2:0] CALC  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]  state;
  logic [15:0] a_q, b_q;
  logic [3:0]  k_a, k_b;
  logic [14:0] f_a, f_b;

  logic [15:0] lod_in;
  logic [3:0]  lod_pos;
  logic [15:0] frac_sum;
  logic [4:0]  exp_sum;

  // Left-justify the operand so the leading one falls off bit 15; the rest is the log fraction.
  function automatic logic [14:0] norm_frac(input logic [15:0] v, input logic [3:0] k);
    logic [15:0] sh;
    sh = v << (4'd15 - k);
    return sh[14:0];
  endfunction

  // Antilog: (1.frac) * 2^E, truncated to integer with no rounding.
  function automatic logic [31:0] antilog(input logic [15:0] m, input logic [4:0] e);
    logic [46:0] w;
    w = {31'd0, m} << e;
    return w[46:15];
  endfunction

  assign lod_in = (state == LOD_B) ? b_q : a_q;

  hierarchical_lod_16bit u_lod (
    .data (lod_in),
    .pos  (lod_pos)
  );

  assign frac_sum = {1'b0, f_a} + {1'b0, f_b};
  assign exp_sum  = {1'b0, k_a} + {1'b0, k_b} + {4'd0, frac_sum[15]};

  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_a      <= '0;
      k_b      <= '0;
      f_a      <= '0;
      f_b      <= '0;
      out_p    <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            if (in_a == 16'd0 || in_b == 16'd0) begin
              out_p <= '0;
              state <= DONE;
            end else begin
              state <= LOD_A;
            end
          end
        end
        LOD_A: begin
          k_a   <= lod_pos;
          f_a   <= norm_frac(a_q, lod_pos);
          state <= LOD_B;
        end
        LOD_B: begin
          k_b   <= lod_pos;
          f_b   <= norm_frac(b_q, lod_pos);
          state <= CALC;
        end
        CALC: begin
          out_p <= antilog({1'b1, frac_sum[14:0]}, exp_sum);
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_mult_seq_ctrl.sv
// Bench for log_mult_seq_ctrl: directed corner products, back-pressure, mid-run reset
// and random operands against an arithmetic Mitchell model.

module tb_log_mult_seq_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_p;
  logic          busy;
  logic [CW-1:0] op_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  log_mult_seq_ctrl #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mitchell product from the log/antilog definition using plain integer arithmetic.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    longint ka, kb, fa, fb, s, e, m;
    if (a == 0 || b == 0) return 32'd0;
    ka = 0; kb = 0;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    fa = (longint'(a) - (longint'(1) << ka)) << (15 - ka);
    fb = (longint'(b) - (longint'(1) << kb)) << (15 - kb);
    s  = fa + fb;
    e  = ka + kb + ((s >= 32768) ? 1 : 0);
    m  = 32768 + (s % 32768);
    return 32'((m << e) >> 15);
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] direct, input bit use_direct);
    int lat;
    chk("ready_before", in_ready, 1'b1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, (a == 0 || b == 0) ? 0 : 3);
    chk("p_model", out_p, model(a, b));
    if (use_direct) chk("p_direct", out_p, direct);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("count", op_count, exp_cnt);
    chk("idle_after", in_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] held;
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_p", out_p, 32'd0);
    chk("rst_count", op_count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd4, 16'd8, 32'd32, 1'b1);
    run_op(16'd3, 16'd3, 32'd8, 1'b1);
    run_op(16'd5, 16'd7, 32'd32, 1'b1);
    run_op(16'd3, 16'd2, 32'd6, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0000, 1'b1);
    run_op(16'd1, 16'd1, 32'd1, 1'b1);
    run_op(16'h8000, 16'h8000, 32'h40000000, 1'b1);
    run_op(16'd0, 16'h1234, 32'd0, 1'b1);

    // Back-pressure with in_valid held high throughout DONE.
    in_a = 16'd9; in_b = 16'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'd2; in_b = 16'd2;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_valid", out_valid, 1'b1);
    held = out_p;
    chk("bp_value", held, model(16'd9, 16'd11));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_stable", out_p, held);
      chk("bp_not_ready", in_ready, 1'b0);
      chk("bp_count", op_count, exp_cnt);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("bp_count_after", op_count, exp_cnt);
    chk("bp_idle", in_ready, 1'b1);
    chk("bp_valid_low", out_valid, 1'b0);

    // out_ready while idle must not count.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_ready_nocount", op_count, exp_cnt);

    // Reset during LOD_B discards the operation.
    in_a = 16'd100; in_b = 16'd200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_in_ready", in_ready, 1'b1);
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_out_p", out_p, 32'd0);
    chk("mid_count", op_count, 0);
    exp_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'd6, 16'd6, 32'd32, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 3) ra = 16'd0;
      if (i % 5 == 2) rb = 16'd1 << (i % 16);
      run_op(ra, rb, 32'd0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
